// File: rtl/vending_if.sv
// vending_if: bundle between the coin/keypad front end and the vending
// controller, plus the controller's dispenser, change-hopper and status
// outputs.
//   master : front end / bench. Drives the coin strobes, select/sel_idx,
//            cancel and restock. Observes every controller output.
//   slave  : vending controller. Takes the strobes and drives dispense,
//            dispense_idx, change_*, coin_reject, credit, sold_out and busy.
interface vending_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 8
);
  localparam int IDX_W = $clog2(N_PROD);

  logic                coin_5;
  logic                coin_10;
  logic                coin_25;
  logic                select;
  logic [IDX_W-1:0]    sel_idx;
  logic                cancel;
  logic                restock;
  logic                dispense;
  logic [IDX_W-1:0]    dispense_idx;
  logic                change_5;
  logic                change_10;
  logic                change_25;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [N_PROD-1:0]   sold_out;
  logic                busy;

  modport master (
    output coin_5, coin_10, coin_25, select, sel_idx, cancel, restock,
    input  dispense, dispense_idx, change_5, change_10, change_25,
           coin_reject, credit, sold_out, busy
  );

  modport slave (
    input  coin_5, coin_10, coin_25, select, sel_idx, cancel, restock,
    output dispense, dispense_idx, change_5, change_10, change_25,
           coin_reject, credit, sold_out, busy
  );
endinterface

// File: rtl/vending_controller.sv
// vending_controller: multi-product vending FSM.
//
// Operation summary:
//   - Accepts 5/10/25 coins into a credit register that is capped at
//     MAX_CREDIT.
//   - Grants a vend against the price table and decrements that product's
//     stock counter.
//   - Returns change (or the whole credit on cancel) as one coin pulse per
//     cycle.
//
// Ports:
//   clk     : clock; all logic is on its rising edge.
//   reset_n : synchronous, active-low reset.
//   bus     : vending_if.slave. Carries the coin strobes, select/sel_idx,
//             cancel and restock in; dispense/dispense_idx,
//             change_5/10/25, coin_reject, credit, sold_out and busy out.
module vending_controller #(
  parameter int                          N_PROD     = 4,
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 200,
  parameter logic [N_PROD*CREDIT_W-1:0]  PRICES     = {8'd100, 8'd75, 8'd60, 8'd50},
  parameter int                          STOCK_W    = 4,
  parameter int                          INIT_STOCK = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  vending_if.slave bus
);
  localparam int IDX_W = $clog2(N_PROD);
  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                reject_reg, reject_next;
  logic [STOCK_W-1:0]  stock_reg [N_PROD];
  logic [CREDIT_W-1:0] price_tab [N_PROD];

  logic                coin_any, coin_multi, coin_fits, coin_take;
  logic [CREDIT_W-1:0] coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                sel_ok;
  logic [CREDIT_W-1:0] vend_rem, change_val, change_rem;
  logic                dec_stock, do_restock;

  genvar gi;
  generate
    for (gi = 0; gi < N_PROD; gi++) begin : g_prod
      assign price_tab[gi]    = PRICES[gi*CREDIT_W +: CREDIT_W];
      assign bus.sold_out[gi] = (stock_reg[gi] == '0);
    end
  endgenerate

  // Only the highest-value strobe counts; any lower one alongside it is
  // rejected.
  always_comb begin
    coin_val = '0;
    if (bus.coin_25)      coin_val = CREDIT_W'(25);
    else if (bus.coin_10) coin_val = CREDIT_W'(10);
    else if (bus.coin_5)  coin_val = CREDIT_W'(5);
  end

  assign coin_any   = bus.coin_5 | bus.coin_10 | bus.coin_25;
  assign coin_multi = (bus.coin_25 & (bus.coin_10 | bus.coin_5)) |
                      (bus.coin_10 & bus.coin_5);
  // The extra bit keeps a sum near the top of the range from wrapping
  // before it is compared with the ceiling.
  assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_val};
  assign coin_fits  = (coin_sum <= SUM_W'(MAX_CREDIT));

  assign sel_ok = bus.select
               && ({1'b0, bus.sel_idx} < (IDX_W+1)'(N_PROD))
               && (stock_reg[bus.sel_idx] != '0)
               && (credit_reg >= price_tab[bus.sel_idx]);

  // Coins count only while collecting. A granted select in the same cycle
  // takes precedence over the coin.
  assign coin_take = coin_any && coin_fits
                  && ((state_reg == S_IDLE) ||
                      (state_reg == S_COLLECT && (bus.cancel || !sel_ok)));
  assign reject_next = coin_any && (coin_multi || !coin_take);

  assign vend_rem   = credit_reg - price_tab[idx_reg];
  assign change_val = (credit_reg >= CREDIT_W'(25)) ? CREDIT_W'(25) :
                      (credit_reg >= CREDIT_W'(10)) ? CREDIT_W'(10) : CREDIT_W'(5);
  assign change_rem = credit_reg - change_val;

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    idx_next    = idx_reg;
    dec_stock   = 1'b0;
    do_restock  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        do_restock = bus.restock;
        if (coin_take) begin
          credit_next = coin_sum[CREDIT_W-1:0];
          state_next  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (coin_take) credit_next = coin_sum[CREDIT_W-1:0];
        if (bus.cancel) begin
          state_next = S_CHANGE;
        end else if (sel_ok) begin
          state_next = S_VEND;
          idx_next   = bus.sel_idx;
        end
      end
      S_VEND: begin
        dec_stock   = 1'b1;
        credit_next = vend_rem;
        state_next  = (vend_rem != '0) ? S_CHANGE : S_IDLE;
      end
      default: begin
        credit_next = change_rem;
        if (change_rem == '0) state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      credit_reg <= '0;
      idx_reg    <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      idx_reg    <= idx_next;
      reject_reg <= reject_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PROD; i++) begin
      if (!reset_n || do_restock)
        stock_reg[i] <= STOCK_W'(INIT_STOCK);
      else if (dec_stock && (idx_reg == IDX_W'(i)))
        stock_reg[i] <= stock_reg[i] - 1'b1;
    end
  end

  assign bus.dispense     = (state_reg == S_VEND);
  assign bus.dispense_idx = (state_reg == S_VEND) ? idx_reg : '0;
  assign bus.busy         = (state_reg == S_VEND) || (state_reg == S_CHANGE);
  assign bus.change_25    = (state_reg == S_CHANGE) && (credit_reg >= CREDIT_W'(25));
  assign bus.change_10    = (state_reg == S_CHANGE) && (credit_reg <  CREDIT_W'(25))
                                                   && (credit_reg >= CREDIT_W'(10));
  assign bus.change_5     = (state_reg == S_CHANGE) && (credit_reg <  CREDIT_W'(10));
  assign bus.coin_reject  = reject_reg;
  assign bus.credit       = credit_reg;
endmodule
